// File: rtl/gcp_pkg.sv
// Shared types, defaults and saturating-counter helpers for the global/choice predictor.
// Optional build macro GCP_STATS_EN adds the stored final prediction to each in-flight entry.
package gcp_pkg;

    localparam int GCP_HIST_W = 12;
    localparam int GCP_CTR_W  = 2;
    localparam int GCP_DEPTH  = 4;

    // The index is prepended by the top, since its width follows HIST_W.
    typedef struct packed {
        logic lp;
        logic gp;
`ifdef GCP_STATS_EN
        logic fp;
`endif
    } gcp_entry_t;

    // Counters are handled at 4 bits, the widest legal CTR_W.
    function automatic logic [3:0] sat_inc(input logic [3:0] v, input int unsigned w);
        logic [3:0] top;
        top = 4'((1 << w) - 1);
        return (v == top) ? v : v + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'd0) ? v : v - 4'd1;
    endfunction

endpackage

// File: rtl/gcp_inflight_fifo.sv
// In-flight prediction FIFO. Pushes while full and pops while empty are ignored.
module gcp_inflight_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/param_choice_predictor.sv
// Tournament global/choice predictor with path history and in-flight FIFO.
// Build macro GCP_STATS_EN adds stat_updates / stat_mispred outputs.
module param_choice_predictor
    import gcp_pkg::*;
#(
    parameter int HIST_W = GCP_HIST_W,
    parameter int CTR_W  = GCP_CTR_W,
    parameter int DEPTH  = GCP_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pred_req,
    input  logic              lp_pred,
    input  logic              upd_valid,
    input  logic              branch_taken,
    output logic              pred_valid,
    output logic              gp_pred,
    output logic              cp_choose_global,
    output logic              final_pred,
    output logic              full,
    output logic              empty,
    output logic [HIST_W-1:0] ghist
`ifdef GCP_STATS_EN
    ,
    output logic [15:0]       stat_updates,
    output logic [15:0]       stat_mispred
`endif
);
    localparam int ENTRIES = 2 ** HIST_W;
    localparam int FW      = HIST_W + $bits(gcp_entry_t);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

    logic [CTR_W-1:0]  gp_tab [ENTRIES];
    logic [CTR_W-1:0]  cp_tab [ENTRIES];

    logic              acc_req, acc_upd;
    logic [CTR_W-1:0]  gp_rd, cp_rd, gp_upd, cp_upd;
    logic              gp_msb, cp_msb, fin;
    gcp_entry_t        push_meta, pop_meta;
    logic [HIST_W-1:0] pop_idx;
    logic [FW-1:0]     push_data, pop_data;

    assign acc_req = pred_req && !full;
    assign acc_upd = upd_valid && !empty;
    assign gp_rd   = gp_tab[ghist];
    assign cp_rd   = cp_tab[ghist];
    assign gp_msb  = gp_rd[CTR_W-1];
    assign cp_msb  = cp_rd[CTR_W-1];
    assign fin     = cp_msb ? gp_msb : lp_pred;

    always_comb begin
        push_meta    = '0;
        push_meta.lp = lp_pred;
        push_meta.gp = gp_msb;
`ifdef GCP_STATS_EN
        push_meta.fp = fin;
`endif
    end

    assign push_data          = {ghist, push_meta};
    assign {pop_idx, pop_meta} = pop_data;

    gcp_inflight_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (acc_req),
        .pop   (acc_upd),
        .din   (push_data),
        .dout  (pop_data),
        .full  (full),
        .empty (empty)
    );

    // The choice counter moves toward global when the stored global guess was right.
    assign gp_upd = CTR_W'(branch_taken ? sat_inc(4'(gp_tab[pop_idx]), CTR_W)
                                        : sat_dec(4'(gp_tab[pop_idx])));
    assign cp_upd = CTR_W'((pop_meta.gp == branch_taken) ? sat_inc(4'(cp_tab[pop_idx]), CTR_W)
                                                         : sat_dec(4'(cp_tab[pop_idx])));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                gp_tab[i] <= CTR_INIT;
                cp_tab[i] <= CTR_INIT;
            end
            ghist            <= '0;
            pred_valid       <= 1'b0;
            gp_pred          <= 1'b0;
            cp_choose_global <= 1'b0;
            final_pred       <= 1'b0;
`ifdef GCP_STATS_EN
            stat_updates     <= '0;
            stat_mispred     <= '0;
`endif
        end else begin
            pred_valid <= acc_req;
            if (acc_req) begin
                gp_pred          <= gp_msb;
                cp_choose_global <= cp_msb;
                final_pred       <= fin;
            end
            // Nonblocking writes keep a same-cycle request on the pre-update tables.
            if (acc_upd) begin
                gp_tab[pop_idx] <= gp_upd;
                if (pop_meta.lp != pop_meta.gp)
                    cp_tab[pop_idx] <= cp_upd;
                ghist <= {ghist[HIST_W-2:0], branch_taken};
`ifdef GCP_STATS_EN
                if (stat_updates != 16'hFFFF)
                    stat_updates <= stat_updates + 16'd1;
                if (pop_meta.fp != branch_taken && stat_mispred != 16'hFFFF)
                    stat_mispred <= stat_mispred + 16'd1;
`endif
            end
        end
    end

endmodule
